tage_predictor_param: RTL and testbench
=======================================

Name: tage_predictor_param

Overview:
Parametrised TAGE conditional-branch predictor with a configurable number of tagged tables and configurable index, tag and counter widths. It has one in-flight branch at a time: predict request → prediction → resolve → table update. On reset it self-initialises by walking all table entries. It drives the real TAGE provider prediction and performs allocation and useful-counter management internally.

Parameters:
NUM_TABLES, 4, number of tagged tables T1..TN (1..8)
BASE_IDX_WIDTH, 10, log2 entries of the bimodal base table T0
IDX_WIDTH, 9, log2 entries per tagged table
TAG_WIDTH, 9, tag bits per tagged entry
CTR_WIDTH, 3, prediction counter width in tagged tables
U_WIDTH, 2, useful-counter width
GHIST_LEN, 130, global history register length; must be >= largest HIST_LENS entry
HIST_LENS, {32'd130,32'd44,32'd15,32'd5}, packed 32-bit history length per table; entry i is for T(i+1)
U_AGE_PERIOD, 262144, updates between u-aging sweeps (used only with the optional feature)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pred_valid_i  in  1  predict request
pred_ready_o  out  1  predictor can accept a request
pc_i  in  32  branch PC, sampled on accept
pred_valid_o  out  1  one-cycle pulse; prediction_o/provider_o are valid
prediction_o  out  1  1 = taken
provider_o  out  $clog2(NUM_TABLES+1)  providing table (0 = base)
resolve_valid_i  in  1  outcome of the in-flight branch
resolve_taken_i  in  1  actual direction

Behaviour:
- Reset value of all outputs is 0. Reset clears ghist, the FSM enters CLEAR, and the clear pointer is set to 0. Reset asserted in any state aborts that state with no table writes.
- FSM states: CLEAR, IDLE, LOOKUP, WAIT, UPDATE, AGE. pred_ready_o = 1 only in IDLE.
- CLEAR: writes one index per cycle, 0..2^max(BASE_IDX_WIDTH,IDX_WIDTH)-1.
  - Base counters are set to 2'b01.
  - Tagged entries are set to valid=0, ctr=weak-NT (2^(CTR_WIDTH-1)-1), u=0, tag=0.
  - Then the FSM goes to IDLE.
- IDLE: on pred_valid_i && pred_ready_o, register the base index, per-table hashed index and per-table hashed tag, then go to LOOKUP.
  - Base index: pc_i[BASE_IDX_WIDTH-1:0].
  - Hashed index i: XOR-fold of pc_i into IDX_WIDTH chunks, XOR the XOR-fold of ghist[HIST_LENS[i]-1:0] into IDX_WIDTH chunks. Partial chunks are zero-extended.
  - Hashed tag i: pc_i[TAG_WIDTH-1:0] ^ fold(hist, TAG_WIDTH) ^ (fold(hist, TAG_WIDTH-1) << 1).
- LOOKUP (1 cycle): read all tables.
  - Hit = valid && tag match.
  - Provider = highest-numbered hitting table, else base. Alt = next-lower hitting table, else base.
  - Taken = counter MSB set.
  - Register prediction_o, provider_o, alt_pred and provider u, set pred_valid_o = 1, then go to WAIT.
  - Latency from accept to pred_valid_o is 2 cycles.
- WAIT: hold prediction_o/provider_o. On resolve_valid_i go to UPDATE. resolve_valid_i in any other state is ignored.
- UPDATE (1 cycle), then go to IDLE:
  - Provider counter: saturating +1 if taken, -1 if not-taken (base counter if provider = 0).
  - If provider > 0 and prediction != alt_pred: provider u saturating +1 if the prediction was correct, else -1.
  - On mispredict with provider < NUM_TABLES: allocate in the lowest-numbered table j > provider with u == 0. The allocated entry gets valid=1, the new tag, ctr = 2^(CTR_WIDTH-1) if taken else 2^(CTR_WIDTH-1)-1, and u=0.
  - If no table j > provider has u == 0, decrement (saturating at 0) u of the indexed entry in every table j > provider; no allocation.
  - ghist <= {ghist[GHIST_LEN-2:0], resolve_taken_i}. Only resolved outcomes enter the history; it is non-speculative.
- All counters saturate; no counter ever wraps.

Optional Feature:
TAGE_U_AGING_EN
- Defined:
  - An update counter increments in UPDATE.
  - When it reaches U_AGE_PERIOD, the counter is cleared and UPDATE goes to AGE instead of IDLE.
  - AGE walks indices 0..2^IDX_WIDTH-1, one per cycle, setting u <= u >> 1 in every tagged table, then goes to IDLE.
  - pred_ready_o = 0 throughout AGE.
- Undefined: there is no counter, no AGE state, and u changes only via UPDATE.

Test Plan:
- Reset: release rst_ni with defaults → pred_ready_o = 0 for exactly 1024 cycles, then 1; all outputs 0 meanwhile. Reasserting rst_ni at cycle 500 restarts the 1024-cycle count.
- Cold predict pc=0x0000_0100 → pred_valid_o is a single pulse 2 cycles after accept, with prediction_o=0 and provider_o=0. pred_ready_o stays 0 until 1 cycle after resolve_valid_i.
- Resolve taken for that branch (mispredict) → T1 entry at the hashed index has valid=1, ctr=4, u=0, and the base counter = 2'b10.
- Alternating T/N stream on pc=0x40 for 60 resolves → last 10 predictions are all correct with provider_o >= 1.
- Preload u=3 in every T1..T4 entry the next lookup will index, then mispredict with provider 0 → no allocation; those u become 2.
- Handshake: resolve_valid_i pulsed in IDLE is ignored. pred_valid_i held during WAIT is not accepted and produces no second pred_valid_o. With TAGE_U_AGING_EN and U_AGE_PERIOD=16, the 16th update → AGE for 512 cycles and u=3 entries become 1.

Source files
------------

// File: rtl/tage_predictor_param.sv
// tage_predictor_param: parametrised TAGE predictor, one branch in flight.
// Define TAGE_U_AGING_EN to add the periodic useful-counter aging sweep.
module tage_predictor_param #(
    parameter int NUM_TABLES     = 4,
    parameter int BASE_IDX_WIDTH = 10,
    parameter int IDX_WIDTH      = 9,
    parameter int TAG_WIDTH      = 9,
    parameter int CTR_WIDTH      = 3,
    parameter int U_WIDTH        = 2,
    parameter int GHIST_LEN      = 130,
    parameter logic [NUM_TABLES*32-1:0] HIST_LENS =
        {32'd130, 32'd44, 32'd15, 32'd5},
    parameter int U_AGE_PERIOD   = 262144
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            pred_valid_i,
    output logic                            pred_ready_o,
    input  logic [31:0]                     pc_i,
    output logic                            pred_valid_o,
    output logic                            prediction_o,
    output logic [$clog2(NUM_TABLES+1)-1:0] provider_o,
    input  logic                            resolve_valid_i,
    input  logic                            resolve_taken_i
);
    localparam int PW    = $clog2(NUM_TABLES + 1);
    localparam int CLR_W = (BASE_IDX_WIDTH > IDX_WIDTH) ?
                           BASE_IDX_WIDTH : IDX_WIDTH;
    localparam int NB    = 2 ** BASE_IDX_WIDTH;
    localparam int NE    = 2 ** IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_WNT =
        CTR_WIDTH'(2 ** (CTR_WIDTH - 1) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_WT =
        CTR_WIDTH'(2 ** (CTR_WIDTH - 1));

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOOKUP,
        S_WAIT,
        S_UPDATE
`ifdef TAGE_U_AGING_EN
        , S_AGE
`endif
    } state_t;

    state_t               state;
    logic [CLR_W-1:0]     clr_ptr;
    logic [GHIST_LEN-1:0] ghist;

    logic [1:0]           base_ctr [NB];
    logic                 t_val [NUM_TABLES][NE];
    logic [TAG_WIDTH-1:0] t_tag [NUM_TABLES][NE];
    logic [CTR_WIDTH-1:0] t_ctr [NUM_TABLES][NE];
    logic [U_WIDTH-1:0]   t_u   [NUM_TABLES][NE];

    logic [BASE_IDX_WIDTH-1:0] bidx_q;
    logic [IDX_WIDTH-1:0]      idx_q [NUM_TABLES];
    logic [IDX_WIDTH-1:0]      idx_c [NUM_TABLES];
    logic [TAG_WIDTH-1:0]      tag_q [NUM_TABLES];
    logic [TAG_WIDTH-1:0]      tag_c [NUM_TABLES];
    logic                      alt_pred_q;
    logic [U_WIDTH-1:0]        prov_u_q;
    logic                      taken_q;

    function automatic logic [31:0] fold_pc(input logic [31:0] pc,
                                            input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = pc;
        for (int b = 0; b < 32; b++) begin
            r = r ^ ({31'd0, t[0]} << (b % w));
            t = t >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] fold_hist(
        input logic [GHIST_LEN-1:0] h, input int len, input int w);
        logic [31:0]          r;
        logic [GHIST_LEN-1:0] t;
        r = '0;
        t = h;
        for (int b = 0; b < GHIST_LEN; b++) begin
            if (b < len) r = r ^ ({31'd0, t[0]} << (b % w));
            t = t >> 1;
        end
        return r;
    endfunction

    function automatic int hlen(input int i);
        return int'(HIST_LENS[32*i +: 32]);
    endfunction

    function automatic logic [1:0] b_step(input logic [1:0] c,
                                          input logic up);
        if (up) return (c == 2'b11) ? c : c + 2'd1;
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [CTR_WIDTH-1:0] c_step(
        input logic [CTR_WIDTH-1:0] c, input logic up);
        if (up) return (c == '1) ? c : c + CTR_WIDTH'(1);
        return (c == '0) ? c : c - CTR_WIDTH'(1);
    endfunction

    function automatic logic [U_WIDTH-1:0] u_step(
        input logic [U_WIDTH-1:0] u, input logic up);
        if (up) return (u == '1) ? u : u + U_WIDTH'(1);
        return (u == '0) ? u : u - U_WIDTH'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_TABLES; i++) begin
            idx_c[i] = IDX_WIDTH'(fold_pc(pc_i, IDX_WIDTH)
                     ^ fold_hist(ghist, hlen(i), IDX_WIDTH));
            tag_c[i] = pc_i[TAG_WIDTH-1:0]
                     ^ TAG_WIDTH'(fold_hist(ghist, hlen(i), TAG_WIDTH))
                     ^ TAG_WIDTH'(fold_hist(ghist, hlen(i),
                                            TAG_WIDTH - 1) << 1);
        end
    end

    // Ascending scan: last hit is the provider, the one before it is alt.
    logic [NUM_TABLES-1:0] hit;
    logic [NUM_TABLES:0]   dir;
    logic [PW-1:0]         prov_c;
    logic [PW-1:0]         alt_c;
    logic [U_WIDTH-1:0]    prov_u_c;

    always_comb begin
        prov_c   = '0;
        alt_c    = '0;
        prov_u_c = '0;
        dir[0]   = base_ctr[bidx_q][1];
        for (int i = 0; i < NUM_TABLES; i++) begin
            hit[i]     = t_val[i][idx_q[i]]
                       && (t_tag[i][idx_q[i]] == tag_q[i]);
            dir[i + 1] = t_ctr[i][idx_q[i]][CTR_WIDTH-1];
            if (hit[i]) begin
                alt_c    = prov_c;
                prov_c   = PW'(i + 1);
                prov_u_c = t_u[i][idx_q[i]];
            end
        end
    end

    logic [NUM_TABLES-1:0] above;
    logic [NUM_TABLES-1:0] alloc_sel;
    logic                  alloc_any;
    logic                  mispred;

    always_comb begin
        mispred   = prediction_o != taken_q;
        above     = '0;
        alloc_sel = '0;
        alloc_any = 1'b0;
        for (int i = 0; i < NUM_TABLES; i++) begin
            above[i] = PW'(i + 1) > provider_o;
            if (above[i] && t_u[i][idx_q[i]] == '0 && !alloc_any) begin
                alloc_sel[i] = 1'b1;
                alloc_any    = 1'b1;
            end
        end
    end

`ifdef TAGE_U_AGING_EN
    localparam int AGE_W = $clog2(U_AGE_PERIOD + 1);
    logic [AGE_W-1:0]     age_cnt;
    logic [IDX_WIDTH-1:0] age_ptr;
`else
    logic unused_age;
    assign unused_age = 1'(U_AGE_PERIOD);
`endif

    always_ff @(posedge clk_i) begin
        case (state)
            S_CLEAR: begin
                if ((clr_ptr >> BASE_IDX_WIDTH) == '0)
                    base_ctr[clr_ptr[BASE_IDX_WIDTH-1:0]] <= 2'b01;
                if ((clr_ptr >> IDX_WIDTH) == '0) begin
                    for (int i = 0; i < NUM_TABLES; i++) begin
                        t_val[i][clr_ptr[IDX_WIDTH-1:0]] <= 1'b0;
                        t_tag[i][clr_ptr[IDX_WIDTH-1:0]] <= '0;
                        t_ctr[i][clr_ptr[IDX_WIDTH-1:0]] <= CTR_WNT;
                        t_u[i][clr_ptr[IDX_WIDTH-1:0]]   <= '0;
                    end
                end
            end
            S_UPDATE: begin
                if (provider_o == '0)
                    base_ctr[bidx_q] <= b_step(base_ctr[bidx_q], taken_q);
                for (int i = 0; i < NUM_TABLES; i++) begin
                    if (provider_o == PW'(i + 1)) begin
                        t_ctr[i][idx_q[i]] <=
                            c_step(t_ctr[i][idx_q[i]], taken_q);
                        if (prediction_o != alt_pred_q)
                            t_u[i][idx_q[i]] <=
                                u_step(prov_u_q, prediction_o == taken_q);
                    end
                    if (mispred && above[i]) begin
                        if (alloc_sel[i]) begin
                            t_val[i][idx_q[i]] <= 1'b1;
                            t_tag[i][idx_q[i]] <= tag_q[i];
                            t_ctr[i][idx_q[i]] <= taken_q ? CTR_WT : CTR_WNT;
                            t_u[i][idx_q[i]]   <= '0;
                        end else if (!alloc_any) begin
                            t_u[i][idx_q[i]] <=
                                u_step(t_u[i][idx_q[i]], 1'b0);
                        end
                    end
                end
            end
`ifdef TAGE_U_AGING_EN
            S_AGE: begin
                for (int i = 0; i < NUM_TABLES; i++)
                    t_u[i][age_ptr] <= t_u[i][age_ptr] >> 1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_CLEAR;
            clr_ptr      <= '0;
            ghist        <= '0;
            bidx_q       <= '0;
            idx_q        <= '{default: '0};
            tag_q        <= '{default: '0};
            pred_valid_o <= 1'b0;
            prediction_o <= 1'b0;
            provider_o   <= '0;
            alt_pred_q   <= 1'b0;
            prov_u_q     <= '0;
            taken_q      <= 1'b0;
`ifdef TAGE_U_AGING_EN
            age_cnt      <= '0;
            age_ptr      <= '0;
`endif
        end else begin
            pred_valid_o <= 1'b0;
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + CLR_W'(1);
                    if (clr_ptr == '1) state <= S_IDLE;
                end
                S_IDLE: begin
                    if (pred_valid_i) begin
                        bidx_q <= pc_i[BASE_IDX_WIDTH-1:0];
                        idx_q  <= idx_c;
                        tag_q  <= tag_c;
                        state  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    prediction_o <= dir[prov_c];
                    provider_o   <= prov_c;
                    alt_pred_q   <= dir[alt_c];
                    prov_u_q     <= prov_u_c;
                    pred_valid_o <= 1'b1;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (resolve_valid_i) begin
                        taken_q <= resolve_taken_i;
                        state   <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    ghist <= {ghist[GHIST_LEN-2:0], taken_q};
`ifdef TAGE_U_AGING_EN
                    if (age_cnt == AGE_W'(U_AGE_PERIOD - 1)) begin
                        age_cnt <= '0;
                        age_ptr <= '0;
                        state   <= S_AGE;
                    end else begin
                        age_cnt <= age_cnt + AGE_W'(1);
                        state   <= S_IDLE;
                    end
`else
                    state <= S_IDLE;
`endif
                end
`ifdef TAGE_U_AGING_EN
                S_AGE: begin
                    age_ptr <= age_ptr + IDX_WIDTH'(1);
                    if (age_ptr == '1) state <= S_IDLE;
                end
`endif
                default: state <= S_CLEAR;
            endcase
        end
    end

    assign pred_ready_o = (state == S_IDLE);

endmodule

// File: tb/tb_tage_predictor_param.sv
// tb_tage_predictor_param: randomized bench against a behavioural TAGE model.
// Covers the reset walk, cold allocation, handshakes and branch streams.
module tb_tage_predictor_param;
    localparam int NT = 4;
    localparam int BW = 10;
    localparam int IW = 9;
    localparam int TW = 9;
    localparam int GL = 130;
    localparam int NE = 512;
    localparam int NB = 1024;

    logic        clk_i;
    logic        rst_ni;
    logic        pred_valid_i;
    logic        pred_ready_o;
    logic [31:0] pc_i;
    logic        pred_valid_o;
    logic        prediction_o;
    logic [2:0]  provider_o;
    logic        resolve_valid_i;
    logic        resolve_taken_i;

    tage_predictor_param dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pred_valid_i    (pred_valid_i),
        .pred_ready_o    (pred_ready_o),
        .pc_i            (pc_i),
        .pred_valid_o    (pred_valid_o),
        .prediction_o    (prediction_o),
        .provider_o      (provider_o),
        .resolve_valid_i (resolve_valid_i),
        .resolve_taken_i (resolve_taken_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer tables, history bit 0 = newest outcome.
    int m_base [NB];
    bit m_v    [NT][NE];
    int m_tag  [NT][NE];
    int m_ctr  [NT][NE];
    int m_u    [NT][NE];
    bit m_h    [GL];
    int m_idx  [NT];
    int m_tg   [NT];
    int m_bi;
    int m_prov;
    bit m_pred;
    bit m_altp;

    function automatic int hl(input int i);
        case (i)
            0: return 5;
            1: return 15;
            2: return 44;
            default: return 130;
        endcase
    endfunction

    function automatic int fold_pc(input logic [31:0] pc, input int w);
        int r = 0;
        for (int b = 0; b < 32; b++)
            if (((pc >> b) & 32'd1) != 0) r = r ^ (1 << (b % w));
        return r;
    endfunction

    function automatic int fold_h(input int len, input int w);
        int r = 0;
        for (int b = 0; b < len; b++)
            if (m_h[b]) r = r ^ (1 << (b % w));
        return r;
    endfunction

    function automatic bit dir_of(input int t);
        if (t == 0) return m_base[m_bi] >= 2;
        return m_ctr[t-1][m_idx[t-1]] >= 4;
    endfunction

    function automatic int sat(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NB; j++) m_base[j] = 1;
        for (int i = 0; i < NT; i++)
            for (int j = 0; j < NE; j++) begin
                m_v[i][j] = 0;
                m_tag[i][j] = 0;
                m_ctr[i][j] = 3;
                m_u[i][j] = 0;
            end
        for (int b = 0; b < GL; b++) m_h[b] = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc);
        int alt;
        alt = 0;
        m_prov = 0;
        m_bi = int'(pc[BW-1:0]);
        for (int i = 0; i < NT; i++) begin
            m_idx[i] = (fold_pc(pc, IW) ^ fold_h(hl(i), IW)) & (NE - 1);
            m_tg[i] = (int'(pc[TW-1:0]) ^ fold_h(hl(i), TW)
                      ^ (fold_h(hl(i), TW - 1) << 1)) & ((1 << TW) - 1);
            if (m_v[i][m_idx[i]] && m_tag[i][m_idx[i]] == m_tg[i]) begin
                alt = m_prov;
                m_prov = i + 1;
            end
        end
        m_pred = dir_of(m_prov);
        m_altp = dir_of(alt);
    endtask

    task automatic model_update(input bit tk);
        int p;
        int found;
        int d;
        p = m_prov;
        d = tk ? 1 : -1;
        if (p == 0) begin
            m_base[m_bi] = sat(m_base[m_bi] + d, 3);
        end else begin
            m_ctr[p-1][m_idx[p-1]] = sat(m_ctr[p-1][m_idx[p-1]] + d, 7);
            if (m_pred != m_altp)
                m_u[p-1][m_idx[p-1]] = sat(m_u[p-1][m_idx[p-1]]
                                       + ((m_pred == tk) ? 1 : -1), 3);
        end
        if (m_pred != tk && p < NT) begin
            found = -1;
            for (int j = p; j < NT; j++)
                if (found < 0 && m_u[j][m_idx[j]] == 0) found = j;
            if (found >= 0) begin
                m_v[found][m_idx[found]] = 1;
                m_tag[found][m_idx[found]] = m_tg[found];
                m_ctr[found][m_idx[found]] = tk ? 4 : 3;
                m_u[found][m_idx[found]] = 0;
            end else begin
                for (int j = p; j < NT; j++)
                    m_u[j][m_idx[j]] = sat(m_u[j][m_idx[j]] - 1, 3);
            end
        end
        for (int b = GL - 1; b > 0; b--) m_h[b] = m_h[b-1];
        m_h[0] = tk;
    endtask

    task automatic do_branch(input logic [31:0] pc, input bit tk,
                             input bit hold, output bit pr, output int pv);
        int n;
        n = 0;
        while (!pred_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("ready_wait", pred_ready_o, 1);
        model_predict(pc);
        pc_i = pc;
        pred_valid_i = 1'b1;
        @(negedge clk_i);
        if (!hold) pred_valid_i = 1'b0;
        check_eq("lookup_no_pulse", pred_valid_o, 0);
        @(negedge clk_i);
        check_eq("pred_pulse", pred_valid_o, 1);
        check_eq("prediction", prediction_o, m_pred);
        check_eq("provider", provider_o, m_prov);
        pr = prediction_o;
        pv = int'(provider_o);
        @(negedge clk_i);
        check_eq("pulse_width", pred_valid_o, 0);
        if (hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk_i);
                check_eq("wait_no_accept", {pred_valid_o, pred_ready_o}, 0);
            end
            pred_valid_i = 1'b0;
        end
        check_eq("wait_hold_pred", prediction_o, m_pred);
        resolve_valid_i = 1'b1;
        resolve_taken_i = tk;
        @(negedge clk_i);
        resolve_valid_i = 1'b0;
        check_eq("update_busy", pred_ready_o, 0);
        @(negedge clk_i);
        check_eq("ready_after_update", pred_ready_o, 1);
        model_update(tk);
    endtask

    task automatic idle_resolve_pulse();
        resolve_valid_i = 1'b1;
        resolve_taken_i = 1'b1;
        @(negedge clk_i);
        resolve_valid_i = 1'b0;
        check_eq("idle_resolve_ignored", {pred_ready_o, pred_valid_o}, 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int bad;
        int good;
        int mism;
        int pv;
        bit pr;
        bit tk;
        logic [31:0] pcs [8];
        int per [8];
        int occ [8];
        int s;

        pred_valid_i = 1'b0;
        resolve_valid_i = 1'b0;
        resolve_taken_i = 1'b0;
        pc_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);

        rst_ni = 1'b1;
        cnt = 0;
        for (int c = 0; c < 500; c++) begin
            if (!pred_ready_o) cnt++;
            @(negedge clk_i);
        end
        check_eq("clear_first500", cnt, 500);
        rst_ni = 1'b0;
        #1;
        check_eq("reset_ready", pred_ready_o, 0);
        check_eq("reset_outputs", {pred_valid_o, prediction_o, provider_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cnt = 0;
        bad = 0;
        while (!pred_ready_o && cnt < 3000) begin
            if (pred_valid_o || prediction_o || provider_o != 0) bad++;
            cnt++;
            @(negedge clk_i);
        end
        check_eq("clear_cycles", cnt, 1024);
        check_eq("clear_outputs_zero", bad, 0);
        model_reset();

        do_branch(32'h0000_0100, 1'b1, 1'b0, pr, pv);
        check_eq("cold_prediction", pr, 0);
        check_eq("cold_provider", pv, 0);
        check_eq("alloc_t1_valid", dut.t_val[0][m_idx[0]], 1);
        check_eq("alloc_t1_ctr", dut.t_ctr[0][m_idx[0]], 4);
        check_eq("alloc_t1_u", dut.t_u[0][m_idx[0]], 0);
        check_eq("alloc_t1_tag", dut.t_tag[0][m_idx[0]], m_tg[0]);
        check_eq("base_ctr_taken", dut.base_ctr[256], 2);
        check_eq("t2_not_alloc", dut.t_val[1][m_idx[1]], 0);

        idle_resolve_pulse();
        do_branch(32'h0000_0200, 1'b0, 1'b1, pr, pv);

        good = 0;
        for (int k = 0; k < 60; k++) begin
            tk = (k % 2) == 0;
            do_branch(32'h0000_0040, tk, 1'b0, pr, pv);
            if (k >= 50 && pr == tk && pv >= 1) good++;
        end
        check_eq("alt_last10_correct", good, 10);

        for (int i = 0; i < 8; i++) begin
            pcs[i] = $urandom & 32'hFFFF_FFFC;
            per[i] = $urandom_range(2, 6);
            occ[i] = 0;
        end
        for (int k = 0; k < 400; k++) begin
            s = $urandom_range(0, 7);
            tk = (occ[s] % per[s]) == 0;
            occ[s]++;
            if ($urandom_range(0, 9) == 0) tk = !tk;
            do_branch(pcs[s], tk, $urandom_range(0, 19) == 0, pr, pv);
            if ($urandom_range(0, 19) == 0) idle_resolve_pulse();
        end

        mism = 0;
        for (int i = 0; i < NT; i++)
            for (int j = 0; j < NE; j++) begin
                if (dut.t_val[i][j] != m_v[i][j]) mism++;
                if (int'(dut.t_tag[i][j]) != m_tag[i][j]) mism++;
                if (int'(dut.t_ctr[i][j]) != m_ctr[i][j]) mism++;
                if (int'(dut.t_u[i][j]) != m_u[i][j]) mism++;
            end
        check_eq("tagged_tables", mism, 0);
        mism = 0;
        for (int j = 0; j < NB; j++)
            if (int'(dut.base_ctr[j]) != m_base[j]) mism++;
        check_eq("base_table", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
